// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Arbitrates two frame requesters onto a single UART transmit core.
// Requesters are granted round-robin on a tie. The granted frame is held on
// uart_data with uart_tx_enable high until the core reports uart_tx_done, or
// until TIMEOUT_CYCLES SEND cycles pass. A fixed idle gap follows every frame.
//
// Ports
//   pclk            clock, all state updates on the rising edge
//   rst             synchronous active-high reset
//   req_valid[1:0]  per-requester frame-pending flag
//   req0_data       frame from requester 0
//   req1_data       frame from requester 1
//   req_ready[1:0]  per-requester accept strobe (registered, one-hot or zero)
//   uart_data       frame to the UART core (registered)
//   uart_tx_enable  transmit enable to the UART core (registered)
//   uart_tx_done    transmit-complete pulse from the UART core
//   grant_id        requester of the current or last frame
//   busy            high whenever the FSM is not in IDLE
//   timeout_err     one-cycle pulse when a frame times out
module uart_tx_arbiter #(
  parameter int DATA_W         = 11,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [DATA_W-1:0] req1_data,
  output logic [1:0]        req_ready,
  output logic [DATA_W-1:0] uart_data,
  output logic              uart_tx_enable,
  input  logic              uart_tx_done,
  output logic              grant_id,
  output logic              busy,
  output logic              timeout_err
);

  // Counter widths are sized to hold their terminal value (at least 1 bit).
  localparam int TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GCNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GCNT_W-1:0] GCNT_LAST = GCNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t            state;
  logic              last_grant;
  logic [TCNT_W-1:0] tcnt;
  logic [GCNT_W-1:0] gcnt;
  logic              sel;

  // Requester choice: a lone request wins outright; on a tie the requester
  // that did not transmit last is chosen.
  function automatic logic pick_requester(input logic [1:0] valid,
                                          input logic       last);
    if (valid == 2'b11) begin
      return ~last;
    end
    return valid[1];
  endfunction

  assign sel  = pick_requester(req_valid, last_grant);
  assign busy = (state != IDLE);

  always_ff @(posedge pclk) begin
    if (rst) begin
      state          <= IDLE;
      req_ready      <= 2'b00;
      uart_data      <= '0;
      uart_tx_enable <= 1'b0;
      timeout_err    <= 1'b0;
      grant_id       <= 1'b0;
      last_grant     <= 1'b1;
      tcnt           <= '0;
      gcnt           <= '0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        // Grant: strobe ready to the chosen requester.
        IDLE: begin
          if (req_valid != 2'b00) begin
            grant_id  <= sel;
            req_ready <= sel ? 2'b10 : 2'b01;
            state     <= LOAD;
          end
        end
        // Transfer: the only state in which requester data is sampled.
        // A withdrawn request abandons the grant without touching last_grant.
        LOAD: begin
          req_ready <= 2'b00;
          if (req_valid[grant_id]) begin
            uart_data      <= grant_id ? req1_data : req0_data;
            uart_tx_enable <= 1'b1;
            last_grant     <= grant_id;
            tcnt           <= '0;
            state          <= SEND;
          end else begin
            state <= IDLE;
          end
        end
        // Transmit: done beats a simultaneous timeout.
        SEND: begin
          if (uart_tx_done) begin
            uart_tx_enable <= 1'b0;
            tcnt           <= '0;
            gcnt           <= '0;
            state          <= GAP;
          end else if (tcnt == TCNT_LAST) begin
            timeout_err    <= 1'b1;
            uart_tx_enable <= 1'b0;
            tcnt           <= '0;
            gcnt           <= '0;
            state          <= GAP;
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end
        // Inter-frame gap: requests are not looked at until IDLE.
        GAP: begin
          if (gcnt == GCNT_LAST) begin
            state <= IDLE;
          end else begin
            gcnt <= gcnt + GCNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int DATA_W = 11;

  logic              pclk;
  logic              rst;
  logic [1:0]        req_valid;
  logic [DATA_W-1:0] req0_data;
  logic [DATA_W-1:0] req1_data;
  logic [1:0]        req_ready;
  logic [DATA_W-1:0] uart_data;
  logic              uart_tx_enable;
  logic              uart_tx_done;
  logic              grant_id;
  logic              busy;
  logic              timeout_err;

  typedef struct packed {
    logic              g;
    logic [DATA_W-1:0] d;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   to_count = 0;

  uart_tx_arbiter #(
    .DATA_W         (DATA_W),
    .GAP_CYCLES     (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .pclk           (pclk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req0_data      (req0_data),
    .req1_data      (req1_data),
    .req_ready      (req_ready),
    .uart_data      (uart_data),
    .uart_tx_enable (uart_tx_enable),
    .uart_tx_done   (uart_tx_done),
    .grant_id       (grant_id),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  // Scoreboard: each rising uart_tx_enable must match the oldest queued frame.
  initial begin
    logic prev_en;
    exp_t e;
    prev_en = 1'b0;
    forever begin
      @(posedge pclk);
      #1;
      if (timeout_err === 1'b1) to_count++;
      if (uart_tx_enable === 1'b1 && prev_en !== 1'b1) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_frame", {21'b0, uart_data}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("sb_data", {21'b0, uart_data}, {21'b0, e.d});
          chk("sb_grant", {31'b0, grant_id}, {31'b0, e.g});
        end
      end
      prev_en = uart_tx_enable;
    end
  end

  initial begin
    logic exp_g;
    rst = 1'b1; req_valid = 2'b00; req0_data = '0; req1_data = '0; uart_tx_done = 1'b0;
    tick(2);
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_data", uart_data, 0);
    chk("rst_en", uart_tx_enable, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    // Single request from requester 0.
    req_valid = 2'b01; req0_data = 11'h2A5; req1_data = 11'h155;
    sb.push_back('{g: 1'b0, d: 11'h2A5});
    tick(1);
    chk("single_ready", req_ready, 2'b01);
    chk("single_en_early", uart_tx_enable, 0);
    chk("single_busy", busy, 1);
    tick(1);
    chk("single_en_lat2", uart_tx_enable, 1);
    chk("single_ready_clr", req_ready, 2'b00);
    chk("single_data", uart_data, 11'h2A5);
    req_valid = 2'b00; req0_data = 11'h7FF;
    tick(9);
    chk("single_en_hold", uart_tx_enable, 1);
    chk("single_data_hold", uart_data, 11'h2A5);
    uart_tx_done = 1'b1;
    tick(1);
    uart_tx_done = 1'b0;
    chk("single_en_off", uart_tx_enable, 0);
    chk("single_gap_busy", busy, 1);
    tick(1);
    chk("single_gap2_busy", busy, 1);
    tick(1);
    chk("single_idle", busy, 0);
    // Done outside SEND has no effect.
    uart_tx_done = 1'b1;
    tick(1);
    uart_tx_done = 1'b0;
    chk("stray_done_busy", busy, 0);
    chk("stray_done_en", uart_tx_enable, 0);

    // Tie after reset: grants alternate 0,1,0,1 with a 2-cycle gap.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    req0_data = 11'h0A1; req1_data = 11'h5B2; req_valid = 2'b11;
    sb.push_back('{g: 1'b0, d: 11'h0A1});
    sb.push_back('{g: 1'b1, d: 11'h5B2});
    sb.push_back('{g: 1'b0, d: 11'h0A1});
    sb.push_back('{g: 1'b1, d: 11'h5B2});
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 1);
      tick(1);
      chk("tie_ready", req_ready, exp_g ? 2'b10 : 2'b01);
      chk("tie_grant", grant_id, exp_g);
      tick(1);
      chk("tie_en", uart_tx_enable, 1);
      tick(2);
      uart_tx_done = 1'b1;
      tick(1);
      uart_tx_done = 1'b0;
      chk("tie_gap1_en", uart_tx_enable, 0);
      chk("tie_gap1_ready", req_ready, 2'b00);
      chk("tie_gap1_busy", busy, 1);
      tick(1);
      chk("tie_gap2_ready", req_ready, 2'b00);
      chk("tie_gap2_busy", busy, 1);
      tick(1);
      chk("tie_idle_busy", busy, 0);
      chk("tie_idle_ready", req_ready, 2'b00);
    end
    req_valid = 2'b00;

    // Timeout: no done for 16 SEND cycles.
    req_valid = 2'b10; req1_data = 11'h3C3;
    sb.push_back('{g: 1'b1, d: 11'h3C3});
    tick(2);
    req_valid = 2'b00;
    chk("to_en", uart_tx_enable, 1);
    tick(15);
    chk("to_not_yet", timeout_err, 0);
    chk("to_en_c16", uart_tx_enable, 1);
    tick(1);
    chk("to_pulse", timeout_err, 1);
    chk("to_en_off", uart_tx_enable, 0);
    chk("to_gap_busy", busy, 1);
    tick(1);
    chk("to_pulse_end", timeout_err, 0);
    chk("to_gap2_busy", busy, 1);
    tick(1);
    chk("to_idle", busy, 0);

    // Done and timeout in the same cycle: done wins.
    req_valid = 2'b01; req0_data = 11'h111;
    sb.push_back('{g: 1'b0, d: 11'h111});
    tick(2);
    req_valid = 2'b00;
    tick(15);
    chk("coll_en_c16", uart_tx_enable, 1);
    uart_tx_done = 1'b1;
    tick(1);
    uart_tx_done = 1'b0;
    chk("coll_no_timeout", timeout_err, 0);
    chk("coll_en_off", uart_tx_enable, 0);
    tick(2);
    chk("coll_idle", busy, 0);

    // Request withdrawn during LOAD.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    req_valid = 2'b01; req0_data = 11'h0F0;
    tick(1);
    chk("wd_ready", req_ready, 2'b01);
    req_valid = 2'b00;
    tick(1);
    chk("wd_no_en", uart_tx_enable, 0);
    chk("wd_idle", busy, 0);
    chk("wd_ready_clr", req_ready, 2'b00);
    req_valid = 2'b11; req0_data = 11'h246; req1_data = 11'h135;
    sb.push_back('{g: 1'b0, d: 11'h246});
    tick(1);
    chk("wd_tie_grant", grant_id, 0);
    chk("wd_tie_ready", req_ready, 2'b01);
    tick(1);
    req_valid = 2'b00;
    uart_tx_done = 1'b1;
    tick(1);
    uart_tx_done = 1'b0;
    tick(2);
    chk("wd_tie_idle", busy, 0);

    // Reset on SEND cycle 5.
    req_valid = 2'b01; req0_data = 11'h0AA;
    sb.push_back('{g: 1'b0, d: 11'h0AA});
    tick(2);
    req_valid = 2'b00;
    tick(4);
    chk("rs_en_before", uart_tx_enable, 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rs_en", uart_tx_enable, 0);
    chk("rs_busy", busy, 0);
    chk("rs_ready", req_ready, 2'b00);
    chk("rs_timeout", timeout_err, 0);
    chk("rs_data", uart_data, 0);
    chk("rs_grant", grant_id, 0);
    req_valid = 2'b11; req0_data = 11'h321; req1_data = 11'h654;
    sb.push_back('{g: 1'b0, d: 11'h321});
    tick(1);
    chk("rs_tie_grant", grant_id, 0);
    chk("rs_tie_ready", req_ready, 2'b01);
    tick(1);
    req_valid = 2'b00;
    uart_tx_done = 1'b1;
    tick(1);
    uart_tx_done = 1'b0;
    tick(2);
    chk("rs_tie_idle", busy, 0);

    tick(3);
    chk("sb_empty", sb.size(), 0);
    chk("timeout_count", to_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have the parameter DATA_W, default 11, giving the frame width passed to the UART core.
REQ-002 The block SHALL have the parameter GAP_CYCLES, default 2, giving the idle cycles enforced between frames; legal values are 1 or more.
REQ-003 The block SHALL have the parameter TIMEOUT_CYCLES, default 4096, giving the maximum number of SEND cycles to wait for uart_tx_done.
REQ-004 The block SHALL have one clock and a reset that is synchronous and active-high, on these ports:
- pclk  in  1  clock, all state on the rising edge
- rst  in  1  synchronous active-high reset
REQ-005 The block SHALL have these requester ports:
- req_valid  in  2  per-requester frame-pending flag
- req0_data  in  DATA_W  frame from requester 0
- req1_data  in  DATA_W  frame from requester 1
- req_ready  out  2  per-requester accept strobe, registered
REQ-006 The block SHALL have these UART core ports:
- uart_data  out  DATA_W  frame to the UART core data_in, registered
- uart_tx_enable  out  1  transmit enable to the UART core, registered
- uart_tx_done  in  1  transmit-complete pulse from the UART core
REQ-007 The block SHALL have these status ports:
- grant_id  out  1  requester of the current or last frame
- busy  out  1  high whenever state is not IDLE
- timeout_err  out  1  one-cycle pulse when a frame times out

Function
REQ-008 The block SHALL implement the states IDLE, LOAD, SEND and GAP, with the state held in a single registered variable.
REQ-009 In IDLE with req_valid==0, the block SHALL stay in IDLE.
REQ-010 In IDLE with one req_valid bit set, the block SHALL select that requester.
REQ-011 In IDLE with req_valid==2'b11, the block SHALL select the requester that is not last_grant (round-robin).
REQ-012 On selection in IDLE, the block SHALL move to LOAD and set grant_id=sel and req_ready[sel]=1 on the same edge; at most one req_ready bit is ever high.
REQ-013 In LOAD, a transfer occurs when req_valid[grant_id]==1; the block SHALL then latch uart_data from that requester, set uart_tx_enable=1, clear req_ready, set last_grant=grant_id and move to SEND.
REQ-014 In LOAD with req_valid[grant_id]==0, the block SHALL clear req_ready, leave last_grant unchanged, return to IDLE and not assert uart_tx_enable.
REQ-015 Latency from req_valid high in IDLE to uart_tx_enable high SHALL be exactly 2 cycles; req_ready SHALL be high for exactly 1 cycle per grant.
REQ-016 In SEND, uart_tx_enable and uart_data SHALL stay constant, and a timeout counter SHALL increment every cycle starting from 0.
REQ-017 In SEND with uart_tx_done==1, the block SHALL clear uart_tx_enable and move to GAP.
REQ-018 In SEND, when the counter equals TIMEOUT_CYCLES-1 and uart_tx_done==0, the block SHALL pulse timeout_err for 1 cycle, clear uart_tx_enable and move to GAP.
REQ-019 If uart_tx_done and the timeout condition occur in the same cycle, uart_tx_done SHALL take priority and timeout_err SHALL stay 0.
REQ-020 uart_tx_done received outside SEND SHALL be ignored.
REQ-021 GAP SHALL last exactly GAP_CYCLES cycles, then the block SHALL enter IDLE; req_valid SHALL be ignored during GAP.
REQ-022 The timeout counter SHALL be wide enough to hold TIMEOUT_CYCLES-1 and SHALL be cleared on entry to SEND and to GAP; the gap counter SHALL be cleared on entry to GAP.
REQ-023 Requester data SHALL be sampled only in LOAD; changes on req0_data or req1_data in any other state SHALL have no effect.
REQ-024 busy SHALL be a combinational decode of state != IDLE.

Reset
REQ-025 While rst==1 at a rising edge, the block SHALL set state to IDLE.
REQ-026 The same reset edge SHALL set req_ready=0, uart_data=0, uart_tx_enable=0, timeout_err=0 and grant_id=0.
REQ-027 The same reset edge SHALL set last_grant=1, so requester 0 wins the first tie, and clear both counters.
REQ-028 Reset during any state, including mid-SEND, SHALL abort the frame; outputs SHALL be at reset values after that edge, and no timeout_err SHALL be raised.

Verification
REQ-029 Single request: req_valid=01, req0_data=11'h2A5, uart_tx_done pulsed 10 cycles into SEND -> req_ready=01 for 1 cycle, uart_tx_enable high 2 cycles after valid, uart_data=11'h2A5, IDLE 2 cycles after done.
REQ-030 Tie after reset: req_valid=11 held -> grants in order 0,1,0,1; each frame separated by 2 GAP cycles.
REQ-031 Timeout: TIMEOUT_CYCLES=16, uart_tx_done never asserted -> timeout_err high exactly once on the 16th SEND cycle, then GAP, then IDLE.
REQ-032 Done/timeout collision: uart_tx_done asserted on SEND cycle 16 with TIMEOUT_CYCLES=16 -> timeout_err stays 0, normal GAP.
REQ-033 Valid withdrawn: req_valid 01 dropped during LOAD -> no uart_tx_enable, IDLE next cycle, and the next tie grants requester 0.
REQ-034 Reset mid-SEND: rst=1 on SEND cycle 5 -> next cycle uart_tx_enable=0, busy=0, req_ready=00, and the next tie grants requester 0.
